div8_seq: RTL and testbench



---
 rtl/arith_pkg.sv | 17 +
 rtl/sub8_stage.sv | 27 ++
 rtl/div8_seq.sv | 107 ++++++++++
 tb/tb_div8_seq.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic datapath blocks.
//   ARITH_W    : operand width of the datapath
//   div_state_t: sequencing states of the sequential divider
//   DIV0_QUOT  : quotient presented when the divisor is zero
package arith_pkg;

  localparam int ARITH_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam logic [7:0] DIV0_QUOT = 8'hFF;

endpackage

// File: rtl/sub8_stage.sv
// Combinational 8-bit subtractor: diff = a - b, formed as a + ~b + 1 through
// a ripple of full-adder cells.
// Ports:
//   a, b      : unsigned operands
//   diff      : 8-bit difference (modulo 256)
//   no_borrow : carry-out of the ripple; 1 when a >= b
module sub8_stage (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] diff,
  output logic       no_borrow
);

  logic [8:0] c;
  logic [7:0] b_inv;

  assign b_inv = ~b;
  assign c[0]  = 1'b1;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign diff[i]  = a[i] ^ b_inv[i] ^ c[i];
    assign c[i + 1] = (a[i] & b_inv[i]) | (a[i] & c[i]) | (b_inv[i] & c[i]);
  end

  assign no_borrow = c[8];

endmodule

// File: rtl/div8_seq.sv
// Sequential 8-bit unsigned restoring divider. One subtract stage is reused
// over eight iterations; operands arrive and results leave on valid/ready
// handshakes.
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready : operand handshake (dividend, divisor)
//   out_valid/out_ready : result handshake (quotient, remainder, div_zero)
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for operands, in_ready=1
// CALC  | one restoring iteration per cycle; one pass-through cycle on /0
// DONE  | result held on outputs until out_ready
module div8_seq
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_W,
  parameter int ITER  = ARITH_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam logic [2:0] LAST_ITER = 3'(ITER - 1);

  div_state_t state;
  logic [7:0] q;
  logic [7:0] r;
  logic [7:0] d;
  logic [2:0] cnt;
  logic       dz;
  logic [7:0] t;
  logic [7:0] s;
  logic       nb;

  // r < d always holds, so r[7] is 0 and the shifted value fits in 8 bits.
  assign t = {r[6:0], q[7]};

  sub8_stage u_sub (
    .a         (t),
    .b         (d),
    .diff      (s),
    .no_borrow (nb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      q     <= '0;
      r     <= '0;
      d     <= '0;
      cnt   <= '0;
      dz    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            d     <= divisor;
            cnt   <= '0;
            state <= CALC;
            if (divisor == '0) begin
              q  <= DIV0_QUOT;
              r  <= dividend;
              dz <= 1'b1;
            end else begin
              q  <= dividend;
              r  <= '0;
              dz <= 1'b0;
            end
          end
        end
        CALC: begin
          // A zero divisor spends one cycle here without iterating, so its
          // result appears one cycle after accept.
          if (dz) begin
            state <= DONE;
          end else begin
            r   <= nb ? s : t;
            q   <= {q[6:0], nb};
            cnt <= cnt + 3'd1;
            if (cnt == LAST_ITER) state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign quotient  = q;
  assign remainder = r;
  assign div_zero  = dz;

endmodule

// File: tb/tb_div8_seq.sv
module tb_div8_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] dividend = 8'd0;
  logic [7:0] divisor = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_zero;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div8_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One division: present operands, wait for accept, then measure the number
  // of rising edges from accept until out_valid. While busy, in_valid stays
  // high with junk operands, which must be ignored. hold>0 stalls out_ready.
  task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] qe, input logic [7:0] re, input logic ze,
                         input int hold, input int exp_wait);
    int waits;
    int lat;
    logic seen;
    @(negedge clk);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    waits = 0;
    while (!in_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (exp_wait >= 0) chki({tag, ".accept_wait"}, waits, exp_wait);
    @(posedge clk);
    #1;
    dividend = ~a;
    divisor  = ~b;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      seen = out_valid;
    end
    in_valid = 1'b0;
    if (hold > 0) out_ready = 1'b0;
    chki({tag, ".latency"}, lat, ze ? 1 : 8);
    chk8({tag, ".quotient"}, quotient, qe);
    chk8({tag, ".remainder"}, remainder, re);
    chk1({tag, ".div_zero"}, div_zero, ze);
    chk1({tag, ".in_ready_busy"}, in_ready, 1'b0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      dividend = 8'(i * 3);
      divisor  = 8'(i + 1);
      @(posedge clk);
      #1;
      chk1({tag, ".hold_valid"}, out_valid, 1'b1);
      chk8({tag, ".hold_quot"}, quotient, qe);
      chk8({tag, ".hold_rem"}, remainder, re);
      chk1({tag, ".hold_in_ready"}, in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    int stale;
    logic [7:0] ra;
    logic [7:0] rb;

    // Reset values while rst_n is low.
    #2;
    chk1("rst.in_ready", in_ready, 1'b1);
    chk1("rst.out_valid", out_valid, 1'b0);
    chk8("rst.quotient", quotient, 8'd0);
    chk8("rst.remainder", remainder, 8'd0);
    chk1("rst.div_zero", div_zero, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run_div("d200_7",   8'd200, 8'd7,   8'd28,  8'd4,  1'b0, 0, 0);
    run_div("d255_1",   8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 0, 1);
    run_div("d5_10",    8'd5,   8'd10,  8'd0,   8'd5,  1'b0, 0, 1);
    run_div("d255_255", 8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 0, 1);
    run_div("d77_0",    8'd77,  8'd0,   8'hFF,  8'd77, 1'b1, 0, 1);
    run_div("d9_3",     8'd9,   8'd3,   8'd3,   8'd0,  1'b0, 0, 1);
    run_div("d100_9",   8'd100, 8'd9,   8'd11,  8'd1,  1'b0, 20, 1);
    run_div("d0_5",     8'd0,   8'd5,   8'd0,   8'd0,  1'b0, 0, 1);
    run_div("d1_255",   8'd1,   8'd255, 8'd0,   8'd1,  1'b0, 0, 1);
    run_div("d128_2",   8'd128, 8'd2,   8'd64,  8'd0,  1'b0, 0, 1);
    run_div("d0_0",     8'd0,   8'd0,   8'hFF,  8'd0,  1'b1, 0, 1);

    // Reset during the 4th CALC cycle of 200/7.
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 8'd200;
    divisor  = 8'd7;
    chk1("rstmid.in_ready_pre", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("rstmid.out_valid", out_valid, 1'b0);
    chk1("rstmid.in_ready", in_ready, 1'b1);
    chk8("rstmid.quotient", quotient, 8'd0);
    chk8("rstmid.remainder", remainder, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) stale++;
    end
    chki("rstmid.stale_results", stale, 0);
    run_div("d13_4", 8'd13, 8'd4, 8'd3, 8'd1, 1'b0, 0, 0);

    // Pseudo-random pairs against the reference operators.
    for (int n = 0; n < 300; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = (n % 17 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      if (rb == 8'd0)
        run_div("rand", ra, rb, 8'hFF, ra, 1'b1, 0, -1);
      else
        run_div("rand", ra, rb, ra / rb, ra % rb, 1'b0, 0, -1);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
